exception_sequencer: RTL
========================

EXCEPTION_SEQUENCER -- requirements
Module: exception_sequencer

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high; ports SHALL be named clk and reset.
REQ-002 The block SHALL have parameter DRAIN_MAX, default 7, giving the maximum DRAIN cycles before an interrupt is forced (range 1..15).
REQ-003 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port iInterrupt, input, 1, external IRQ level.
REQ-006 The block SHALL have port iUndefinedInst, input, 1, ID-stage opcode undefined.
REQ-007 The block SHALL have port iKernelMode, input, 1, IF PC bit 31.
REQ-008 The block SHALL have port iBranchInFlight, input, 1, branch or jump unresolved in ID/EX.
REQ-009 The block SHALL have port iLoadUseStall, input, 1, hazard unit stalling ID.
REQ-010 The block SHALL have port iID_PC, input, 32, PC of the ID-stage instruction.
REQ-011 The block SHALL have port oPCSel, output, 2, PC select: 00 normal, 01 IRQ vector, 10 exception vector.
REQ-012 The block SHALL have port oFlush_IF_ID, output, 1, squash the IF/ID register.
REQ-013 The block SHALL have port oFlush_ID_EX, output, 1, squash the ID/EX register.
REQ-014 The block SHALL have port oEPC, output, 32, saved return address for $26.
REQ-015 The block SHALL have port oEPCWrite, output, 1, one-cycle write strobe to $26.
REQ-016 The block SHALL have port oIrqAck, output, 1, one-cycle interrupt acknowledge.
REQ-017 The block SHALL have port oDoubleFault, output, 1, sticky fault flag.
REQ-018 The block SHALL have port oState, output, 2, FSM state for debug.

Function
REQ-019 The FSM SHALL have states IDLE=0, DRAIN=1, VECTOR=2 and KERNEL=3.
REQ-020 An IRQ pending latch SHALL set when the (optionally synchronised) iInterrupt=1 and iKernelMode=0, and SHALL clear only in VECTOR with cause IRQ.
REQ-021 In IDLE, iUndefinedInst=1 SHALL take priority: go to VECTOR, cause EXC, next cycle.
REQ-022 In IDLE with pending IRQ and no blocker, the FSM SHALL go to VECTOR with cause IRQ; a blocker is iBranchInFlight or iLoadUseStall; with pending IRQ and a blocker it SHALL go to DRAIN.
REQ-023 In DRAIN, a drain counter SHALL increment each cycle; the FSM SHALL go to VECTOR when the blocker clears or the counter reaches DRAIN_MAX; the counter SHALL reset on DRAIN exit.
REQ-024 In DRAIN, iUndefinedInst=1 SHALL pre-empt: go to VECTOR with cause EXC, IRQ stays pending.
REQ-025 VECTOR SHALL last exactly one cycle, asserting oFlush_IF_ID=1, oFlush_ID_EX=1 and oEPCWrite=1.
REQ-026 In VECTOR, oPCSel SHALL be 01 for IRQ or 10 for EXC.
REQ-027 In VECTOR, oEPC SHALL load iID_PC for IRQ (resume the squashed instruction) or iID_PC+4 for EXC (32-bit wrap).
REQ-028 In VECTOR, oIrqAck SHALL assert for IRQ only; VECTOR SHALL be followed by KERNEL.
REQ-029 KERNEL SHALL hold until iKernelMode=0 (return via jr $26), then go to IDLE; IRQs SHALL stay masked, but pending IRQs SHALL be retained.
REQ-030 iUndefinedInst=1 in KERNEL SHALL set oDoubleFault, with no vector and no EPC write.
REQ-031 oDoubleFault SHALL be sticky until reset.
REQ-032 Outside VECTOR, oPCSel SHALL be 00 and all strobes SHALL be 0; oEPC SHALL hold its last value.
REQ-033 Simultaneous IRQ and undefined instruction SHALL take the exception first; the IRQ SHALL be taken on the first IDLE cycle after return.

Reset
REQ-034 Reset SHALL force state IDLE, clear the pending latch, drain counter, synchroniser flops and oDoubleFault, and set oEPC=0.
REQ-035 Reset SHALL win over any in-progress transition, including mid-VECTOR; no strobe SHALL be asserted in the reset cycle.

Configuration
REQ-036 With IRQ_SYNC_EN defined, iInterrupt SHALL pass a two-flop synchroniser (+2 cycles latency).
REQ-037 Without IRQ_SYNC_EN, iInterrupt SHALL be sampled directly into the pending latch (0 added latency).

Structure
REQ-038 Package mips_pkg SHALL hold the state encoding, the PCSel codes and the vectors 32'h80000004 (IRQ) and 32'h80000008 (EXC).
REQ-039 The synchroniser SHALL be sub-module irq_sync, instantiated only under IRQ_SYNC_EN.

Verification
REQ-040 Test: IRQ in IDLE, no blockers, iID_PC=0x00000040 -> VECTOR with oPCSel=01, oEPC=0x00000040, oIrqAck=1 for one cycle, then KERNEL.
REQ-041 Test: undefined instruction at iID_PC=0x0000FFFC -> oPCSel=10, oEPC=0x00010000; at iID_PC=0xFFFFFFFC -> oEPC=0x00000000.
REQ-042 Test: IRQ with iBranchInFlight held 3 cycles -> DRAIN for 3 cycles, then VECTOR; with the blocker held 20 cycles and DRAIN_MAX=7 -> forced VECTOR after 7 DRAIN cycles.
REQ-043 Test: IRQ and undefined instruction in the same cycle -> EXC vector; iKernelMode falls -> IDLE, then IRQ vector the next cycle.
REQ-044 Test: undefined instruction in KERNEL -> oDoubleFault=1 and held; reset -> 0.
REQ-045 Test: reset asserted during VECTOR -> next cycle IDLE, oEPC=0, oEPCWrite=0; with IRQ_SYNC_EN, IRQ-to-VECTOR latency increases by 2 cycles.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg - shared encodings for the exception sequencer. Rev 1.0
`default_nettype none

package mips_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_VECTOR = 2'd2;
  localparam logic [1:0] ST_KERNEL = 2'd3;

  localparam logic [1:0] PCSEL_NORMAL = 2'b00;
  localparam logic [1:0] PCSEL_IRQ    = 2'b01;
  localparam logic [1:0] PCSEL_EXC    = 2'b10;

  localparam logic [31:0] IRQ_VECTOR = 32'h80000004;
  localparam logic [31:0] EXC_VECTOR = 32'h80000008;

  // IRQs resume the squashed ID instruction; exceptions skip past it.
  function automatic logic [31:0] epc_value(input logic cause_irq, input logic [31:0] pc);
    return cause_irq ? pc : pc + 32'd4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_sync.sv
// irq_sync - two-flop synchroniser for the external interrupt level. Rev 1.0
`default_nettype none

module irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] sync_ff;

  always_ff @(posedge clk) begin
    if (reset) sync_ff <= 2'b00;
    else       sync_ff <= {sync_ff[0], d};
  end

  assign q = sync_ff[1];

endmodule

`default_nettype wire

// File: rtl/exception_sequencer.sv
// exception_sequencer - IRQ/exception sequencing FSM; define IRQ_SYNC_EN for a
// two-flop interrupt synchroniser. Rev 1.0
`default_nettype none

module exception_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned DRAIN_MAX = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iInterrupt,
  input  logic        iUndefinedInst,
  input  logic        iKernelMode,
  input  logic        iBranchInFlight,
  input  logic        iLoadUseStall,
  input  logic [31:0] iID_PC,
  output logic [1:0]  oPCSel,
  output logic        oFlush_IF_ID,
  output logic        oFlush_ID_EX,
  output logic [31:0] oEPC,
  output logic        oEPCWrite,
  output logic        oIrqAck,
  output logic        oDoubleFault,
  output logic [1:0]  oState
);

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_MAX - 1);

  logic [1:0]  state, state_next;
  logic        cause_irq, cause_irq_next;
  logic        irq_pending;
  logic [3:0]  drain_cnt;
  logic [31:0] epc_q;
  logic [31:0] epc_now;
  logic        double_fault;
  logic        irq_in;
  logic        blocker;
  logic        in_vector;

`ifdef IRQ_SYNC_EN
  irq_sync u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .d     (iInterrupt),
    .q     (irq_in)
  );
`else
  assign irq_in = iInterrupt;
`endif

  assign blocker = iBranchInFlight | iLoadUseStall;
  assign epc_now = epc_value(cause_irq, iID_PC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cause_irq <= 1'b0;
    end else begin
      state     <= state_next;
      cause_irq <= cause_irq_next;
    end
  end

  always_comb begin
    state_next     = state;
    cause_irq_next = cause_irq;
    case (state)
      ST_IDLE: begin
        if (iUndefinedInst) begin
          state_next     = ST_VECTOR;
          cause_irq_next = 1'b0;
        end else if (irq_pending) begin
          if (blocker) begin
            state_next = ST_DRAIN;
          end else begin
            state_next     = ST_VECTOR;
            cause_irq_next = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (iUndefinedInst) begin
          state_next     = ST_VECTOR;
          cause_irq_next = 1'b0;
        end else if (!blocker || drain_cnt == DRAIN_LAST) begin
          state_next     = ST_VECTOR;
          cause_irq_next = 1'b1;
        end
      end
      ST_VECTOR: state_next = ST_KERNEL;
      ST_KERNEL: if (!iKernelMode) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Strobes are gated by reset so a reset landing mid-VECTOR emits nothing.
  always_comb begin
    in_vector    = (state == ST_VECTOR) && !reset;
    oPCSel       = PCSEL_NORMAL;
    oFlush_IF_ID = 1'b0;
    oFlush_ID_EX = 1'b0;
    oEPCWrite    = 1'b0;
    oIrqAck      = 1'b0;
    oEPC         = epc_q;
    if (in_vector) begin
      oPCSel       = cause_irq ? PCSEL_IRQ : PCSEL_EXC;
      oFlush_IF_ID = 1'b1;
      oFlush_ID_EX = 1'b1;
      oEPCWrite    = 1'b1;
      oIrqAck      = cause_irq;
      oEPC         = epc_now;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_pending  <= 1'b0;
      drain_cnt    <= 4'd0;
      epc_q        <= 32'd0;
      double_fault <= 1'b0;
    end else begin
      if (state == ST_VECTOR && cause_irq)  irq_pending <= 1'b0;
      else if (irq_in && !iKernelMode)      irq_pending <= 1'b1;
      if (state == ST_DRAIN && state_next == ST_DRAIN) drain_cnt <= drain_cnt + 4'd1;
      else                                             drain_cnt <= 4'd0;
      if (state == ST_VECTOR) epc_q <= epc_now;
      if (state == ST_KERNEL && iUndefinedInst) double_fault <= 1'b1;
    end
  end

  assign oDoubleFault = double_fault;
  assign oState       = state;

endmodule

`default_nettype wire
